// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
//
// Purpose: arbiter state encoding, default parameter values and the data
// value returned to the pipeline when a memory access is aborted by timeout.
// Ports: none (package).

package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    DONE_I,
    DONE_D
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT    = 255;
  localparam int STARVE_MAX_DEFAULT = 4;

  localparam logic [31:0] TIMEOUT_FILL = 32'h0000_0000;

endpackage

// File: rtl/mem_arb_watchdog.sv
// rtl/mem_arb_watchdog.sv - BUSY-cycle watchdog for the memory port arbiter
//
// Purpose: counts cycles spent waiting on memory and flags the cycle in which
// the wait budget is used up.
// Ports:
//   clk     - clock
//   reset   - synchronous active-high reset
//   clear   - restart the count (asserted on entry to a memory access)
//   enable  - a waiting cycle is in progress
//   expired - this enabled cycle is the TIMEOUT-th one

module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // count_q holds the number of enabled cycles already completed, so the
  // current cycle is number count_q+1; saturation keeps the count from
  // wrapping if enable is left high.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CW'(TIMEOUT))) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto a single memory port
//
// Purpose: shares one memory port between instruction fetch and data access,
// with data priority bounded by a starvation counter and a watchdog that
// releases the pipeline if memory never answers.
// Ports:
//   clk, reset                     - clock, synchronous active-high reset
//   InstrReqF, PCF                 - fetch request and address
//   InstrF, InstrValidF            - fetched word and completion pulse
//   DataReqM, DataWeM              - data request and write enable
//   DataAddrM, DataWdM             - data address and write data
//   DataRdM, DataValidM            - read data and completion pulse
//   MemReq, MemWe, MemAddr, MemWd  - memory request side
//   MemRd, MemReady                - memory response side
//   StallIF, StallMem              - stalls to the hazard unit
//   ErrTimeout                     - sticky memory timeout flag

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEFAULT,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        InstrReqF,
  input  logic [31:0] PCF,
  output logic [31:0] InstrF,
  output logic        InstrValidF,
  input  logic        DataReqM,
  input  logic        DataWeM,
  input  logic [31:0] DataAddrM,
  input  logic [31:0] DataWdM,
  output logic [31:0] DataRdM,
  output logic        DataValidM,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWd,
  input  logic [31:0] MemRd,
  input  logic        MemReady,
  output logic        StallIF,
  output logic        StallMem,
  output logic        ErrTimeout
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIMIT = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   rd_q, rd_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic busy;
  logic fetch_starved;
  logic grant_data;
  logic grant_fetch;
  logic wdog_clear;
  logic wdog_expired;

  assign busy          = (state_q == BUSY_I) || (state_q == BUSY_D);
  // Data normally wins a tie; once the fetch has lost STARVE_MAX ties in a
  // row it is given the port.
  assign fetch_starved = InstrReqF && (starve_q == STARVE_LIMIT);
  assign grant_data    = DataReqM && !fetch_starved;
  assign grant_fetch   = InstrReqF && !grant_data;

  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (wdog_clear),
    .enable (busy),
    .expired(wdog_expired)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wd_d       = wd_q;
    we_d       = we_q;
    instr_d    = instr_q;
    rd_d       = rd_q;
    err_d      = err_q;
    starve_d   = starve_q;
    wdog_clear = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d    = BUSY_D;
          addr_d     = DataAddrM;
          we_d       = DataWeM;
          wd_d       = DataWdM;
          wdog_clear = 1'b1;
          if (InstrReqF && (starve_q != STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (grant_fetch) begin
          state_d    = BUSY_I;
          addr_d     = PCF;
          we_d       = 1'b0;
          wd_d       = 32'h0000_0000;
          starve_d   = '0;
          wdog_clear = 1'b1;
        end
      end
      // MemReady is checked before the watchdog so a response arriving in
      // the last allowed cycle is taken as a normal completion.
      BUSY_I: begin
        if (MemReady) begin
          instr_d = MemRd;
          state_d = DONE_I;
        end else if (wdog_expired) begin
          instr_d = TIMEOUT_FILL;
          err_d   = 1'b1;
          state_d = DONE_I;
        end
      end
      BUSY_D: begin
        if (MemReady) begin
          if (!we_q) begin
            rd_d = MemRd;
          end
          state_d = DONE_D;
        end else if (wdog_expired) begin
          if (!we_q) begin
            rd_d = TIMEOUT_FILL;
          end
          err_d   = 1'b1;
          state_d = DONE_D;
        end
      end
      DONE_I, DONE_D: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'h0000_0000;
      wd_q     <= 32'h0000_0000;
      we_q     <= 1'b0;
      instr_q  <= 32'h0000_0000;
      rd_q     <= 32'h0000_0000;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
      instr_q  <= instr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign MemReq      = busy;
  assign MemWe       = we_q;
  assign MemAddr     = addr_q;
  assign MemWd       = wd_q;
  assign InstrF      = instr_q;
  assign DataRdM     = rd_q;
  assign InstrValidF = (state_q == DONE_I);
  assign DataValidM  = (state_q == DONE_D);
  assign StallIF     = InstrReqF && (state_q != DONE_I);
  assign StallMem    = DataReqM && (state_q != DONE_D);
  assign ErrTimeout  = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed scoreboard bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        InstrReqF;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        DataReqM;
  logic        DataWeM;
  logic [31:0] DataAddrM;
  logic [31:0] DataWdM;
  logic [31:0] DataRdM;
  logic        DataValidM;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWd;
  logic [31:0] MemRd;
  logic        MemReady;
  logic        StallIF;
  logic        StallMem;
  logic        ErrTimeout;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .TIMEOUT   (8),
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .InstrReqF  (InstrReqF),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .InstrValidF(InstrValidF),
    .DataReqM   (DataReqM),
    .DataWeM    (DataWeM),
    .DataAddrM  (DataAddrM),
    .DataWdM    (DataWdM),
    .DataRdM    (DataRdM),
    .DataValidM (DataValidM),
    .MemReq     (MemReq),
    .MemWe      (MemWe),
    .MemAddr    (MemAddr),
    .MemWd      (MemWd),
    .MemRd      (MemRd),
    .MemReady   (MemReady),
    .StallIF    (StallIF),
    .StallMem   (StallMem),
    .ErrTimeout (ErrTimeout)
  );

  typedef struct {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic is_d, input logic [31:0] addr, input logic we,
                      input logic [31:0] wd, input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.addr = addr;
    e.we   = we;
    e.wd   = wd;
    e.data = data;
    sb.push_back(e);
  endtask

  // Waits for the next grant, answers it after `delay` BUSY cycles (never if
  // delay < 0), checks the completion, then optionally drops requests
  // (drop[1] fetch, drop[0] data) in the following IDLE cycle.
  task automatic serve(input int delay, input logic [31:0] rd, input logic [1:0] drop,
                       output int nbusy);
    exp_t e;
    int   waitc;
    nbusy = 0;
    waitc = 0;
    tick();
    while (MemReq !== 1'b1 && waitc < 16) begin
      tick();
      waitc++;
    end
    chk("grant_seen", {31'b0, MemReq}, 32'd1);
    if (MemReq !== 1'b1) return;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL sb_underflow: observed depth %0d expected at least 1", sb.size());
    end
    if (sb.size() == 0) return;
    e = sb.pop_front();
    while (MemReq === 1'b1 && nbusy < 40) begin
      MemReady = (nbusy == delay);
      MemRd    = MemReady ? rd : 32'h5A5A_5A5A;
      smp();
      chk("busy_addr", MemAddr, e.addr);
      chk("busy_we", {31'b0, MemWe}, {31'b0, e.we});
      chk("busy_wd", MemWd, e.wd);
      chk("busy_stall_if", {31'b0, StallIF}, {31'b0, InstrReqF});
      chk("busy_stall_mem", {31'b0, StallMem}, {31'b0, DataReqM});
      chk("busy_no_valid", {30'b0, InstrValidF, DataValidM}, 32'd0);
      tick();
      nbusy++;
    end
    MemReady = 1'b0;
    MemRd    = 32'h0;
    smp();
    chk("valid_i", {31'b0, InstrValidF}, {31'b0, !e.is_d});
    chk("valid_d", {31'b0, DataValidM}, {31'b0, e.is_d});
    chk("done_data", e.is_d ? DataRdM : InstrF, e.data);
    chk("done_stall_if", {31'b0, StallIF}, {31'b0, InstrReqF & e.is_d});
    chk("done_stall_mem", {31'b0, StallMem}, {31'b0, DataReqM & !e.is_d});
    chk("done_memreq", {31'b0, MemReq}, 32'd0);
    tick();
    if (drop[1]) InstrReqF = 1'b0;
    if (drop[0]) begin
      DataReqM = 1'b0;
      DataWeM  = 1'b0;
    end
    smp();
    chk("pulse_end", {30'b0, InstrValidF, DataValidM}, 32'd0);
    chk("idle_stall_if", {31'b0, StallIF}, {31'b0, InstrReqF});
    chk("idle_stall_mem", {31'b0, StallMem}, {31'b0, DataReqM});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete within time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int          n;
    logic [31:0] last_rd;

    reset     = 1'b1;
    InstrReqF = 1'b1;
    DataReqM  = 1'b1;
    DataWeM   = 1'b0;
    PCF       = 32'h1234_5678;
    DataAddrM = 32'h8765_4321;
    DataWdM   = 32'h0;
    MemRd     = 32'h0;
    MemReady  = 1'b0;

    // Reset with both requests high: IDLE, cleared outputs, stalls live.
    tick();
    tick();
    smp();
    chk("rst_memreq", {31'b0, MemReq}, 32'd0);
    chk("rst_memwe", {31'b0, MemWe}, 32'd0);
    chk("rst_memaddr", MemAddr, 32'd0);
    chk("rst_memwd", MemWd, 32'd0);
    chk("rst_instr", InstrF, 32'd0);
    chk("rst_rd", DataRdM, 32'd0);
    chk("rst_valids", {30'b0, InstrValidF, DataValidM}, 32'd0);
    chk("rst_err", {31'b0, ErrTimeout}, 32'd0);
    chk("rst_stall_if", {31'b0, StallIF}, 32'd1);
    chk("rst_stall_mem", {31'b0, StallMem}, 32'd1);
    tick();
    reset     = 1'b0;
    InstrReqF = 1'b0;
    DataReqM  = 1'b0;
    smp();
    chk("post_rst_stall_if", {31'b0, StallIF}, 32'd0);

    // Single fetch with immediate response; a stray MemReady in IDLE is ignored.
    tick();
    InstrReqF = 1'b1;
    PCF       = 32'h0040_0000;
    MemReady  = 1'b1;
    MemRd     = 32'hDEAD_0001;
    push(1'b0, 32'h0040_0000, 1'b0, 32'h0, 32'h2008_0005);
    smp();
    chk("f1_stall_t0", {31'b0, StallIF}, 32'd1);
    chk("f1_no_req_t0", {31'b0, MemReq}, 32'd0);
    serve(0, 32'h2008_0005, 2'b11, n);
    chk("f1_busy_cycles", n, 32'd1);

    // Simultaneous fetch and data read: data first, fetch second.
    tick();
    InstrReqF = 1'b1;
    PCF       = 32'h0040_0004;
    DataReqM  = 1'b1;
    DataWeM   = 1'b0;
    DataAddrM = 32'h1000_0004;
    DataWdM   = 32'h0;
    push(1'b1, 32'h1000_0004, 1'b0, 32'h0, 32'hA5A5_0004);
    push(1'b0, 32'h0040_0004, 1'b0, 32'h0, 32'h0000_0013);
    smp();
    chk("both_stall_if", {31'b0, StallIF}, 32'd1);
    serve(3, 32'hA5A5_0004, 2'b01, n);
    chk("both_d_cycles", n, 32'd4);
    serve(3, 32'h0000_0013, 2'b11, n);
    chk("both_i_cycles", n, 32'd4);
    last_rd = 32'hA5A5_0004;

    // Write: MemWe/MemWd presented, read data register untouched.
    tick();
    DataReqM  = 1'b1;
    DataWeM   = 1'b1;
    DataAddrM = 32'h1000_0100;
    DataWdM   = 32'hCAFE_F00D;
    push(1'b1, 32'h1000_0100, 1'b1, 32'hCAFE_F00D, last_rd);
    serve(1, 32'h1111_2222, 2'b11, n);
    chk("wr_busy_cycles", n, 32'd2);

    // Starvation: four data grants, then the waiting fetch, then data again.
    tick();
    InstrReqF = 1'b1;
    PCF       = 32'h0040_0008;
    DataReqM  = 1'b1;
    DataWeM   = 1'b0;
    DataAddrM = 32'h1000_0200;
    DataWdM   = 32'h0000_0077;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) push(1'b0, 32'h0040_0008, 1'b0, 32'h0, 32'hB000_0000 + k);
      else        push(1'b1, 32'h1000_0200, 1'b0, 32'h0000_0077, 32'hB000_0000 + k);
    end
    for (int k = 0; k < 6; k++) begin
      serve(k % 3, 32'hB000_0000 + k, (k == 5) ? 2'b11 : 2'b00, n);
      chk("starve_cycles", n, (k % 3) + 1);
    end

    // Timeout: memory never answers a read.
    chk("pre_to_err", {31'b0, ErrTimeout}, 32'd0);
    tick();
    DataReqM  = 1'b1;
    DataWeM   = 1'b0;
    DataAddrM = 32'h1000_0300;
    DataWdM   = 32'h0;
    push(1'b1, 32'h1000_0300, 1'b0, 32'h0, 32'h0000_0000);
    serve(-1, 32'hFFFF_FFFF, 2'b11, n);
    chk("to_busy_cycles", n, 32'd8);
    chk("to_err_set", {31'b0, ErrTimeout}, 32'd1);

    // Normal read afterwards: flag stays set.
    tick();
    DataReqM  = 1'b1;
    DataAddrM = 32'h1000_0304;
    push(1'b1, 32'h1000_0304, 1'b0, 32'h0, 32'h0BAD_CAFE);
    serve(2, 32'h0BAD_CAFE, 2'b11, n);
    chk("to_err_sticky", {31'b0, ErrTimeout}, 32'd1);

    // Reset in the middle of BUSY: aborted, no valid pulse.
    tick();
    DataReqM  = 1'b1;
    DataAddrM = 32'h1000_0400;
    smp();
    tick();
    MemReady = 1'b0;
    smp();
    chk("mid_busy_req", {31'b0, MemReq}, 32'd1);
    tick();
    reset    = 1'b1;
    DataReqM = 1'b0;
    smp();
    tick();
    smp();
    chk("mid_rst_memreq", {31'b0, MemReq}, 32'd0);
    chk("mid_rst_valids", {30'b0, InstrValidF, DataValidM}, 32'd0);
    chk("mid_rst_err", {31'b0, ErrTimeout}, 32'd0);
    chk("mid_rst_addr", MemAddr, 32'd0);
    chk("mid_rst_rd", DataRdM, 32'd0);
    tick();
    reset = 1'b0;
    smp();
    chk("mid_rst_after1", {29'b0, InstrValidF, DataValidM, MemReq}, 32'd0);
    tick();
    smp();
    chk("mid_rst_after2", {29'b0, InstrValidF, DataValidM, MemReq}, 32'd0);

    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
